bubble_sort_ctrl: RTL and testbench
===================================

Name: bubble_sort_ctrl

Overview:
- Sequencer for the bubble-sort datapath. It holds an N-entry element bank and runs compare/swap passes over it.
- One adjacent pair is compared and conditionally swapped per cycle.
- It sits behind the AXI4-Lite slave register block. The host loads elements, pulses start, waits for done, then reads the sorted elements back.
- It also reports swap and pass statistics for the status registers.

Parameters:
- N, 4, number of elements (N >= 2).
- DATA_W, 32, element width in bits.
- SIGNED, 0, 1 = two's-complement compare; 0 = unsigned compare.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  host write strobe into the element bank.
- wr_addr  in  $clog2(N)  element index to write.
- wr_data  in  DATA_W  element value.
- rd_addr  in  $clog2(N)  element index to read.
- rd_data  out  DATA_W  combinational read of elem[rd_addr].
- start  in  1  sort request; sampled only in IDLE.
- busy  out  1  high while in SORT.
- done  out  1  one-cycle pulse when the sort completes.
- swap_count  out  SWAP_W  swaps performed by the last or current sort.
- pass_count  out  PASS_W  passes completed by the last or current sort.

Behaviour:
- Reset:
  - State goes to IDLE; all elem[] cleared to 0.
  - busy=0, done=0, swap_count=0, pass_count=0, j=0, pass_swapped=0.
  - Reset during SORT aborts immediately; no done pulse.
- States: IDLE, SORT, DONE.
- IDLE:
  - If wr_en, elem[wr_addr] <= wr_data. An out-of-range wr_addr is ignored.
  - If start: clear swap_count, pass_count, j and pass_swapped; go to SORT.
  - wr_en and start in the same cycle: the write lands first, and the sort uses the updated bank.
- SORT (one pair per cycle):
  - Compare elem[j] with elem[j+1]. Swap iff elem[j] > elem[j+1] (strict, so equal values never swap).
  - Comparison is signed or unsigned per SIGNED.
  - On a swap: increment swap_count and set pass_swapped.
  - End of pass is when j == N-2-pass_count. Then j <= 0, pass_count++, pass_swapped <= 0.
  - Go to DONE when the incremented pass_count == N-1, or per the early-exit rule (Optional Feature).
  - Otherwise j++.
  - wr_en and start are ignored in SORT.
- DONE: done=1 and busy=0 for one cycle, then IDLE. start is ignored in DONE.
- Latency without early exit: start sampled at cycle 0, SORT occupies cycles 1..N(N-1)/2, done at cycle N(N-1)/2+1. For N=4, done is at cycle 7.
- Widths:
  - SWAP_W = $clog2(N(N-1)/2+1).
  - PASS_W = $clog2(N).
  - Counters never wrap: the maximum is reached exactly at completion.
- rd_data is valid in every state. Reads during SORT return in-flight values, which is not an error.

Optional Feature:
- Macro: BUBBLE_SORT_EARLY_EXIT_EN.
- Defined: at the end of a pass with pass_swapped==0 (including a swap in the pass's final cycle), go to DONE after that pass. pass_count still increments for that pass.
- Undefined: always exactly N-1 passes, so latency is fixed at N(N-1)/2+1 cycles.

Decomposition:
- Package bubble_sort_pkg:
  - state enum (IDLE, SORT, DONE).
  - functions computing SWAP_W and PASS_W from N.
  - element typedef parameterised by DATA_W via a localparam default.
- Sub-module bubble_sort_cmp_swap:
  - Combinational.
  - Inputs: a, b, signed_mode.
  - Outputs: lo, hi, swap.
  - The controller instantiates one and writes lo/hi back to elem[j]/elem[j+1].

Test Plan:
- Reverse order, N=4, DATA_W=32, early exit off: load 4,3,2,1; start.
  - Expect done at cycle 7, busy high for cycles 1..6.
  - Expect elements 1,2,3,4, swap_count=6, pass_count=3.
- Already sorted: load 1,2,3,4; start.
  - With EARLY_EXIT_EN: done at cycle 4, swap_count=0, pass_count=1.
  - Without: done at cycle 7, swap_count=0, pass_count=3.
- Duplicates and signed compare:
  - SIGNED=0, load 5,5,5,5: no swaps, swap_count=0.
  - SIGNED=1, load 0,0xFFFFFFFF,2,1: result 0xFFFFFFFF,0,1,2.
  - SIGNED=0, same input: result 0,1,2,0xFFFFFFFF.
- Protocol:
  - During SORT, wr_en to addr 0 with 0xDEAD and a start pulse are both ignored. Only one done is seen, and results are unaffected.
  - wr_en+start in the same IDLE cycle: the written value is included in the sort.
- Reset mid-sort: assert reset at cycle 3 of a 4,3,2,1 sort.
  - Next cycle: state IDLE, busy=0, no done, all rd_data=0, counters 0.
  - A fresh load of 4,3,2,1 then sorts correctly.

Source files
------------

// File: rtl/bubble_sort_pkg.sv
// Shared types and width helpers for the bubble-sort sequencer.
// Optional early-exit behaviour is selected with BUBBLE_SORT_EARLY_EXIT_EN.
package bubble_sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DATA_W_DEFAULT = 32;

  typedef logic [DATA_W_DEFAULT-1:0] elem_t;

  // Sized so the counter reaches its maximum exactly at completion, never wrapping.
  function automatic int swap_width(input int n);
    return $clog2(n * (n - 1) / 2 + 1);
  endfunction

  function automatic int pass_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// Host-side bus of the bubble-sort sequencer: element bank access, start/done
// handshake and statistics. master = host/register block, slave = controller.
interface bubble_sort_ctrl_if #(
  parameter int N      = 4,
  parameter int DATA_W = 32
) ();
  import bubble_sort_pkg::*;

  localparam int AW     = $clog2(N);
  localparam int SWAP_W = swap_width(N);
  localparam int PASS_W = pass_width(N);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [SWAP_W-1:0] swap_count;
  logic [PASS_W-1:0] pass_count;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    output start,
    input  rd_data,
    input  busy,
    input  done,
    input  swap_count,
    input  pass_count
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    input  start,
    output rd_data,
    output busy,
    output done,
    output swap_count,
    output pass_count
  );

endinterface

// File: rtl/bubble_sort_cmp_swap.sv
// Combinational compare/exchange cell: orders one adjacent pair and flags a
// strict-greater swap, in signed or unsigned arithmetic.
module bubble_sort_cmp_swap
  import bubble_sort_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              signed_mode,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi,
  output logic              swap
);

  logic a_gt_b;

  // Strict compare so equal values keep their order and never count as a swap.
  always_comb begin
    if (signed_mode) begin
      a_gt_b = $signed(a) > $signed(b);
    end else begin
      a_gt_b = a > b;
    end
  end

  assign swap = a_gt_b;
  assign lo   = a_gt_b ? b : a;
  assign hi   = a_gt_b ? a : b;

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer: N-entry element bank, one compare/swap per cycle,
// swap/pass statistics. Define BUBBLE_SORT_EARLY_EXIT_EN to stop after a clean pass.
module bubble_sort_ctrl
  import bubble_sort_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int SIGNED = 0
) (
  input  logic              clock,
  input  logic              reset,
  bubble_sort_ctrl_if.slave bus
);

  localparam int AW     = $clog2(N);
  localparam int SWAP_W = swap_width(N);
  localparam int PASS_W = pass_width(N);

  localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(N - 1);
  localparam logic [AW-1:0]     FIRST_LAST_J = AW'(N - 2);
  localparam logic              SIGNED_MODE = (SIGNED != 0);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] elem_q [N];
  logic [DATA_W-1:0] elem_d [N];
  logic [AW-1:0]     j_q, j_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [SWAP_W-1:0] swap_q, swap_d;
  logic              pass_swapped_q, pass_swapped_d;

  logic [AW-1:0]     j_p1;
  logic [PASS_W-1:0] pass_inc;
  logic              end_of_pass;
  logic              swapped_now;
  logic [DATA_W-1:0] cmp_a, cmp_b, cmp_lo, cmp_hi;
  logic              cmp_swap;

  assign j_p1     = j_q + 1'b1;
  assign pass_inc = pass_q + 1'b1;

  // Each pass is one compare shorter than the previous one.
  assign end_of_pass = (j_q == (FIRST_LAST_J - AW'(pass_q)));
  assign swapped_now = pass_swapped_q | cmp_swap;

  assign cmp_a = elem_q[j_q];
  assign cmp_b = elem_q[j_p1];

  bubble_sort_cmp_swap #(
    .DATA_W (DATA_W)
  ) u_cmp_swap (
    .a           (cmp_a),
    .b           (cmp_b),
    .signed_mode (SIGNED_MODE),
    .lo          (cmp_lo),
    .hi          (cmp_hi),
    .swap        (cmp_swap)
  );

  // Element bank next state: host writes only in IDLE, pair write-back only in SORT.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      elem_d[i] = elem_q[i];
      if (state_q == IDLE) begin
        if (bus.wr_en && (bus.wr_addr == AW'(i))) begin
          elem_d[i] = bus.wr_data;
        end
      end else if (state_q == SORT) begin
        if (j_q == AW'(i)) begin
          elem_d[i] = cmp_lo;
        end else if (j_p1 == AW'(i)) begin
          elem_d[i] = cmp_hi;
        end
      end
    end
  end

  // Sequencer next state and statistics.
  always_comb begin
    state_d        = state_q;
    j_d            = j_q;
    pass_d         = pass_q;
    swap_d         = swap_q;
    pass_swapped_d = pass_swapped_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          j_d            = '0;
          pass_d         = '0;
          swap_d         = '0;
          pass_swapped_d = 1'b0;
          state_d        = SORT;
        end
      end

      SORT: begin
        if (cmp_swap) begin
          swap_d = swap_q + 1'b1;
        end
        if (end_of_pass) begin
          j_d            = '0;
          pass_d         = pass_inc;
          pass_swapped_d = 1'b0;
          if (pass_inc == LAST_PASS) begin
            state_d = DONE;
          end
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
          else if (!swapped_now) begin
            state_d = DONE;
          end
`endif
        end else begin
          j_d            = j_p1;
          pass_swapped_d = swapped_now;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      j_q            <= '0;
      pass_q         <= '0;
      swap_q         <= '0;
      pass_swapped_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        elem_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      j_q            <= j_d;
      pass_q         <= pass_d;
      swap_q         <= swap_d;
      pass_swapped_q <= pass_swapped_d;
      for (int i = 0; i < N; i++) begin
        elem_q[i] <= elem_d[i];
      end
    end
  end

  // Read port is combinational so the host sees in-flight values during SORT.
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.rd_addr == AW'(i)) begin
        bus.rd_data = elem_q[i];
      end
    end
  end

  assign bus.busy       = (state_q == SORT);
  assign bus.done       = (state_q == DONE);
  assign bus.swap_count = swap_q;
  assign bus.pass_count = pass_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Self-checking bench: an unsigned and a signed sequencer share one host stimulus;
// directed table, protocol/reset sequences and random arrays against a sort model.
module tb_bubble_sort_ctrl;
  import bubble_sort_pkg::*;

  localparam int NE    = 4;
  localparam int AW_TB = $clog2(NE);
  localparam int MAXC  = 20;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef logic [NE-1:0][31:0] warr_t;
  typedef struct packed {
    warr_t v;
    warr_t exp;
    int    sw;
    int    ps_full;
    int    ps_ee;
    int    cyc_full;
    int    cyc_ee;
  } vec_t;

  logic             clock   = 1'b0;
  logic             reset   = 1'b1;
  logic             wr_en   = 1'b0;
  logic             start   = 1'b0;
  logic [AW_TB-1:0] wr_addr = '0;
  logic [AW_TB-1:0] rd_addr = '0;
  elem_t            wr_data = '0;

  int total = 0;
  int bad   = 0;

  warr_t obs_v    [2];
  int    obs_sw   [2];
  int    obs_ps   [2];
  int    obs_cyc  [2];
  int    obs_dcnt [2];
  int    obs_bcnt [2];
  int    obs_bend [2];

  vec_t tbl [5];

  bubble_sort_ctrl_if #(.N(NE), .DATA_W(32)) if_u ();
  bubble_sort_ctrl_if #(.N(NE), .DATA_W(32)) if_s ();

  assign if_u.wr_en   = wr_en;
  assign if_u.wr_addr = wr_addr;
  assign if_u.wr_data = wr_data;
  assign if_u.rd_addr = rd_addr;
  assign if_u.start   = start;
  assign if_s.wr_en   = wr_en;
  assign if_s.wr_addr = wr_addr;
  assign if_s.wr_data = wr_data;
  assign if_s.rd_addr = rd_addr;
  assign if_s.start   = start;

  bubble_sort_ctrl #(.N(NE), .DATA_W(32), .SIGNED(0)) u_dut_u (
    .clock (clock),
    .reset (reset),
    .bus   (if_u.slave)
  );

  bubble_sort_ctrl #(.N(NE), .DATA_W(32), .SIGNED(1)) u_dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (if_s.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic busy_of(input int d);
    return (d == 0) ? if_u.busy : if_s.busy;
  endfunction

  function automatic logic done_of(input int d);
    return (d == 0) ? if_u.done : if_s.done;
  endfunction

  function automatic bit greater(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    if (sgn) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Textbook bubble sort with per-pass bookkeeping; one compare costs one cycle.
  task automatic model(input warr_t in_v, input bit sgn, output warr_t out_v,
                       output int sw, output int ps, output int cyc);
    warr_t       a;
    bit          any;
    logic [31:0] t;
    a   = in_v;
    sw  = 0;
    ps  = 0;
    cyc = 0;
    for (int p = 0; p < NE - 1; p++) begin
      any = 1'b0;
      for (int j = 0; j < NE - 1 - p; j++) begin
        cyc++;
        if (greater(a[j], a[j+1], sgn)) begin
          t      = a[j];
          a[j]   = a[j+1];
          a[j+1] = t;
          sw++;
          any = 1'b1;
        end
      end
      ps++;
      if (EARLY && !any) break;
    end
    out_v = a;
    cyc   = cyc + 1;
  endtask

  function automatic vec_t mk(input logic [31:0] a0, a1, a2, a3, e0, e1, e2, e3,
                              input int sw, psf, pse, cf, ce);
    vec_t r;
    r.v[0] = a0; r.v[1] = a1; r.v[2] = a2; r.v[3] = a3;
    r.exp[0] = e0; r.exp[1] = e1; r.exp[2] = e2; r.exp[3] = e3;
    r.sw = sw; r.ps_full = psf; r.ps_ee = pse; r.cyc_full = cf; r.cyc_ee = ce;
    return r;
  endfunction

  // Load, start (cycle 0), watch MAXC cycles, then read back both banks.
  task automatic do_sort(input warr_t v, input bit inject, input bit wr_with_start);
    logic b;
    logic dn;
    for (int i = 0; i < NE; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW_TB'(i);
      wr_data = (wr_with_start && i == NE - 1) ? 32'd9 : v[i];
      tick();
    end
    wr_en = 1'b0;
    if (wr_with_start) begin
      wr_en   = 1'b1;
      wr_addr = AW_TB'(NE - 1);
      wr_data = v[NE-1];
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      obs_cyc[d]  = -1;
      obs_dcnt[d] = 0;
      obs_bcnt[d] = 0;
      obs_bend[d] = -1;
    end
    for (int c = 1; c <= MAXC; c++) begin
      for (int d = 0; d < 2; d++) begin
        b  = busy_of(d);
        dn = done_of(d);
        if (dn === 1'b1) begin
          obs_dcnt[d]++;
          if (obs_cyc[d] < 0) obs_cyc[d] = c;
        end
        if (b === 1'b1) obs_bcnt[d]++;
        else if (obs_bend[d] < 0) obs_bend[d] = c;
      end
      if (inject && c == 2) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 32'hDEAD;
        start   = 1'b1;
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NE; i++) begin
      rd_addr = AW_TB'(i);
      #1;
      obs_v[0][i] = if_u.rd_data;
      obs_v[1][i] = if_s.rd_data;
    end
    obs_sw[0] = int'(if_u.swap_count);
    obs_ps[0] = int'(if_u.pass_count);
    obs_sw[1] = int'(if_s.swap_count);
    obs_ps[1] = int'(if_s.pass_count);
  endtask

  task automatic check_dut(input string tag, input int d, input warr_t ev,
                           input int esw, input int eps, input int ecyc);
    for (int i = 0; i < NE; i++) begin
      chk($sformatf("%s d%0d elem%0d", tag, d, i), obs_v[d][i], ev[i]);
    end
    chk($sformatf("%s d%0d swap_count", tag, d), obs_sw[d], esw);
    chk($sformatf("%s d%0d pass_count", tag, d), obs_ps[d], eps);
    chk($sformatf("%s d%0d done_cycle", tag, d), obs_cyc[d], ecyc);
    chk($sformatf("%s d%0d done_pulses", tag, d), obs_dcnt[d], 1);
    chk($sformatf("%s d%0d busy_cycles", tag, d), obs_bcnt[d], ecyc - 1);
    chk($sformatf("%s d%0d busy_end", tag, d), obs_bend[d], ecyc);
  endtask

  task automatic check_model(input string tag, input warr_t v, input bit only_signed);
    warr_t ev;
    int    esw, eps, ecyc;
    for (int d = (only_signed ? 1 : 0); d < 2; d++) begin
      model(v, d == 1, ev, esw, eps, ecyc);
      check_dut(tag, d, ev, esw, eps, ecyc);
    end
    $display("txn %s: in=%h u_done@%0d s_done@%0d u_swaps=%0d s_swaps=%0d",
             tag, v, obs_cyc[0], obs_cyc[1], obs_sw[0], obs_sw[1]);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " busy_u"}, if_u.busy, 1'b0);
    chk({tag, " busy_s"}, if_s.busy, 1'b0);
    chk({tag, " done_u"}, if_u.done, 1'b0);
    chk({tag, " done_s"}, if_s.done, 1'b0);
    chk({tag, " swap_u"}, if_u.swap_count, 0);
    chk({tag, " pass_u"}, if_u.pass_count, 0);
    chk({tag, " swap_s"}, if_s.swap_count, 0);
    chk({tag, " pass_s"}, if_s.pass_count, 0);
    for (int i = 0; i < NE; i++) begin
      rd_addr = AW_TB'(i);
      #1;
      chk($sformatf("%s rd_u%0d", tag, i), if_u.rd_data, 0);
      chk($sformatf("%s rd_s%0d", tag, i), if_s.rd_data, 0);
    end
  endtask

  initial begin
    warr_t v;
    warr_t exp_s;
    int    dcount;

    tbl[0] = mk(4, 3, 2, 1, 1, 2, 3, 4, 6, 3, 3, 7, 7);
    tbl[1] = mk(1, 2, 3, 4, 1, 2, 3, 4, 0, 3, 1, 7, 4);
    tbl[2] = mk(5, 5, 5, 5, 5, 5, 5, 5, 0, 3, 1, 7, 4);
    tbl[3] = mk(0, 32'hFFFF_FFFF, 2, 1, 0, 1, 2, 32'hFFFF_FFFF, 3, 3, 3, 7, 7);
    tbl[4] = mk(2, 1, 3, 4, 1, 2, 3, 4, 1, 3, 2, 7, 6);

    reset = 1'b1;
    tick();
    tick();
    check_cleared("reset");
    reset = 1'b0;
    tick();

    // Directed table: unsigned instance against fixed expectations, signed against model.
    for (int k = 0; k < 5; k++) begin
      do_sort(tbl[k].v, 1'b0, 1'b0);
      check_dut($sformatf("tbl%0d", k), 0, tbl[k].exp, tbl[k].sw,
                EARLY ? tbl[k].ps_ee : tbl[k].ps_full,
                EARLY ? tbl[k].cyc_ee : tbl[k].cyc_full);
      check_model($sformatf("tbl%0d", k), tbl[k].v, 1'b1);
      if (k == 3) begin
        exp_s[0] = 32'hFFFF_FFFF;
        exp_s[1] = 32'd0;
        exp_s[2] = 32'd1;
        exp_s[3] = 32'd2;
        for (int i = 0; i < NE; i++) begin
          chk($sformatf("signed_neg elem%0d", i), obs_v[1][i], exp_s[i]);
        end
      end
    end

    // Write and start while sorting must be ignored.
    v[0] = 4; v[1] = 3; v[2] = 2; v[3] = 1;
    do_sort(v, 1'b1, 1'b0);
    check_model("inject", v, 1'b0);

    // Write coinciding with start lands before the first compare.
    v[0] = 4; v[1] = 3; v[2] = 2; v[3] = 1;
    do_sort(v, 1'b0, 1'b1);
    check_model("wr_start", v, 1'b0);

    // Reset asserted during cycle 3 of a sort.
    for (int i = 0; i < NE; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW_TB'(i);
      wr_data = 32'(NE - i);
      tick();
    end
    wr_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cleared("midreset");
    dcount = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (if_u.done === 1'b1 || if_s.done === 1'b1) dcount++;
    end
    chk("midreset no_done", dcount, 0);
    $display("txn midreset: done pulses after abort=%0d", dcount);
    v[0] = 4; v[1] = 3; v[2] = 2; v[3] = 1;
    do_sort(v, 1'b0, 1'b0);
    check_model("after_reset", v, 1'b0);

    // Random arrays; odd runs use a tiny range to force duplicates.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NE; i++) begin
        v[i] = (r % 2 == 1) ? 32'($urandom_range(0, 5)) : 32'($urandom());
      end
      do_sort(v, 1'b0, 1'b0);
      check_model($sformatf("rand%0d", r), v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
